// File: rtl/clock_set_ctrl_if.sv
// Button, current-time and edit-result signals between the board front end and Digital_Clock.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_alarm;
  logic       btn_inc;
  logic       btn_set;
  logic [7:0] cur_hh;
  logic [7:0] cur_mm;
  logic [7:0] cur_ss;
  logic [7:0] hh_in;
  logic [7:0] mm_in;
  logic [7:0] ss_in;
  logic       load;
  logic       put_alarm;
  logic       editing;
  logic [1:0] field_sel;
  logic       target_alarm;

  modport master (
    output btn_mode, btn_alarm, btn_inc, btn_set, cur_hh, cur_mm, cur_ss,
    input  hh_in, mm_in, ss_in, load, put_alarm, editing, field_sel, target_alarm
  );

  modport slave (
    input  btn_mode, btn_alarm, btn_inc, btn_set, cur_hh, cur_mm, cur_ss,
    output hh_in, mm_in, ss_in, load, put_alarm, editing, field_sel, target_alarm
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Debounced push-button editor for time and alarm of Digital_Clock: BCD field edit,
// commit via single-cycle load / put_alarm pulse, idle timeout abort.
module clock_set_ctrl #(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  clock_set_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, EDIT_HH, EDIT_MM, EDIT_SS, COMMIT} state_t;

  // Wraps to 00 at the field limit and on any non-BCD input.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v >= max_v) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Bit order for all button vectors: {set, mode, alarm, inc}
  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q, deb_q, deb_d, pulse_q, pulse_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  state_t        state_q, state_d;
  logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [7:0]    ahh_q, ahh_d, amm_q, amm_d, ass_q, ass_d;
  logic          tgt_q, tgt_d;
  logic [TW-1:0] to_q, to_d;
  logic          load_q, load_d, put_q, put_d, edit_q, edit_d;
  logic [1:0]    fsel_q, fsel_d;
  logic          go_set, go_mode, go_alarm, go_inc;

  assign raw = {bus.btn_set, bus.btn_mode, bus.btn_alarm, bus.btn_inc};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i]   = deb_q[i];
      cnt_d[i]   = '0;
      pulse_d[i] = 1'b0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_MAX) begin
          deb_d[i]   = ~deb_q[i];
          pulse_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign go_set   = pulse_q[3];
  assign go_mode  = pulse_q[2] & ~pulse_q[3];
  assign go_alarm = pulse_q[1] & ~(|pulse_q[3:2]);
  assign go_inc   = pulse_q[0] & ~(|pulse_q[3:1]);

  always_comb begin
    state_d = state_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    ahh_d   = ahh_q;
    amm_d   = amm_q;
    ass_d   = ass_q;
    tgt_d   = tgt_q;
    to_d    = '0;
    case (state_q)
      IDLE: begin
        if (go_mode) begin
          hh_d    = bus.cur_hh;
          mm_d    = bus.cur_mm;
          ss_d    = bus.cur_ss;
          tgt_d   = 1'b0;
          state_d = EDIT_HH;
        end else if (go_alarm) begin
          hh_d    = ahh_q;
          mm_d    = amm_q;
          ss_d    = ass_q;
          tgt_d   = 1'b1;
          state_d = EDIT_HH;
        end
      end
      EDIT_HH, EDIT_MM, EDIT_SS: begin
        if (go_set) begin
          state_d = COMMIT;
        end else if (go_mode) begin
          state_d = (state_q == EDIT_HH) ? EDIT_MM :
                    (state_q == EDIT_MM) ? EDIT_SS : EDIT_HH;
        end else if (go_inc) begin
          if (state_q == EDIT_HH)      hh_d = bcd_inc(hh_q, 8'h23);
          else if (state_q == EDIT_MM) mm_d = bcd_inc(mm_q, 8'h59);
          else                         ss_d = bcd_inc(ss_q, 8'h59);
        end
        // Ignored alarm presses do not count as activity.
        if (!(go_set || go_mode || go_inc)) begin
          if (to_q == TO_MAX) state_d = IDLE;
          else                to_d    = to_q + 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (tgt_q) begin
          ahh_d = hh_q;
          amm_d = mm_q;
          ass_d = ss_q;
        end
      end
      default: state_d = IDLE;
    endcase

    edit_d = (state_d == EDIT_HH) || (state_d == EDIT_MM) || (state_d == EDIT_SS);
    case (state_d)
      EDIT_HH: fsel_d = 2'd1;
      EDIT_MM: fsel_d = 2'd2;
      EDIT_SS: fsel_d = 2'd3;
      default: fsel_d = 2'd0;
    endcase
    load_d = (state_d == COMMIT) && !tgt_d;
    put_d  = (state_d == COMMIT) &&  tgt_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      pulse_q <= '0;
      cnt_q   <= '{default: '0};
      state_q <= IDLE;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      ahh_q   <= '0;
      amm_q   <= '0;
      ass_q   <= '0;
      tgt_q   <= 1'b0;
      to_q    <= '0;
      load_q  <= 1'b0;
      put_q   <= 1'b0;
      edit_q  <= 1'b0;
      fsel_q  <= 2'd0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      ahh_q   <= ahh_d;
      amm_q   <= amm_d;
      ass_q   <= ass_d;
      tgt_q   <= tgt_d;
      to_q    <= to_d;
      load_q  <= load_d;
      put_q   <= put_d;
      edit_q  <= edit_d;
      fsel_q  <= fsel_d;
    end
  end

  assign bus.hh_in        = hh_q;
  assign bus.mm_in        = mm_q;
  assign bus.ss_in        = ss_q;
  assign bus.load         = load_q;
  assign bus.put_alarm    = put_q;
  assign bus.editing      = edit_q;
  assign bus.field_sel    = fsel_q;
  assign bus.target_alarm = tgt_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: expected commits are queued at stimulus time and
// popped by a monitor whenever load or put_alarm is seen.
module tb_clock_set_ctrl;
  localparam int DEB  = 4;
  localparam int TMO  = 200;
  localparam int HOLD = DEB + 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_e;
  logic        prev_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: {put_alarm, hh, mm, ss}
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_pulse = 1'b0;
    end else if (bus.load || bus.put_alarm) begin
      chk("pulse_exclusive", {31'b0, bus.load & bus.put_alarm}, 32'd0);
      chk("pulse_width", {31'b0, prev_pulse}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got load=%b put_alarm=%b %h:%h:%h expected no pulse",
                 bus.load, bus.put_alarm, bus.hh_in, bus.mm_in, bus.ss_in);
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit", {7'b0, bus.put_alarm, bus.hh_in, bus.mm_in, bus.ss_in}, {7'b0, mon_e});
      end
      prev_pulse = 1'b1;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // b = {set, mode, alarm, inc}
  task automatic press(input logic [3:0] b);
    @(negedge clk);
    {bus.btn_set, bus.btn_mode, bus.btn_alarm, bus.btn_inc} = b;
    repeat (HOLD) @(negedge clk);
    {bus.btn_set, bus.btn_mode, bus.btn_alarm, bus.btn_inc} = 4'b0000;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic inc_n(input int n);
    for (int i = 0; i < n; i++) press(4'b0001);
  endtask

  initial begin
    reset = 1'b0;
    {bus.btn_set, bus.btn_mode, bus.btn_alarm, bus.btn_inc} = 4'b0000;
    bus.cur_hh = 8'h12;
    bus.cur_mm = 8'h34;
    bus.cur_ss = 8'h56;
    repeat (3) @(negedge clk);
    chk("rst_editing", {31'b0, bus.editing}, 32'd0);
    chk("rst_field", {30'b0, bus.field_sel}, 32'd0);
    chk("rst_pulses", {30'b0, bus.load, bus.put_alarm}, 32'd0);
    chk("rst_time", {8'b0, bus.hh_in, bus.mm_in, bus.ss_in}, 32'd0);
    chk("rst_target", {31'b0, bus.target_alarm}, 32'd0);
    reset = 1'b1;

    // Two-cycle glitch must be filtered
    @(negedge clk);
    bus.btn_mode = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_editing", {31'b0, bus.editing}, 32'd0);

    // Debounced press: pulse after edge DEB+3, FSM reacts on the following edge
    bus.btn_mode = 1'b1;
    repeat (DEB + 3) @(negedge clk);
    chk("entry_early", {31'b0, bus.editing}, 32'd0);
    @(negedge clk);
    chk("entry_editing", {31'b0, bus.editing}, 32'd1);
    bus.btn_mode = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("entry_field", {30'b0, bus.field_sel}, 32'd1);
    chk("entry_seed", {8'b0, bus.hh_in, bus.mm_in, bus.ss_in}, 32'h00123456);
    chk("entry_target", {31'b0, bus.target_alarm}, 32'd0);

    inc_n(10);
    chk("hh_22", {24'b0, bus.hh_in}, 32'h22);
    inc_n(1);
    chk("hh_23", {24'b0, bus.hh_in}, 32'h23);
    inc_n(1);
    chk("hh_wrap", {24'b0, bus.hh_in}, 32'h00);

    press(4'b0100);
    chk("field_mm", {30'b0, bus.field_sel}, 32'd2);
    inc_n(25);
    chk("mm_59", {24'b0, bus.mm_in}, 32'h59);
    inc_n(1);
    chk("mm_wrap", {16'b0, bus.hh_in, bus.mm_in}, 32'h0000);
    inc_n(2);

    press(4'b0100);
    chk("field_ss", {30'b0, bus.field_sel}, 32'd3);
    inc_n(3);
    chk("ss_59", {24'b0, bus.ss_in}, 32'h59);
    inc_n(1);
    chk("ss_wrap", {24'b0, bus.ss_in}, 32'h00);
    inc_n(9);
    chk("ss_09", {24'b0, bus.ss_in}, 32'h09);
    inc_n(1);
    chk("ss_carry", {24'b0, bus.ss_in}, 32'h10);
    inc_n(30);
    press(4'b0100);
    chk("field_wrap_hh", {30'b0, bus.field_sel}, 32'd1);

    exp_q.push_back({1'b0, 8'h00, 8'h02, 8'h40});
    press(4'b1000);
    chk("commit_idle", {30'b0, bus.editing, bus.field_sel != 2'd0}, 32'd0);
    chk("commit_hold", {8'b0, bus.hh_in, bus.mm_in, bus.ss_in}, 32'h00000240);

    // IDLE ignores inc and set
    press(4'b0001);
    press(4'b1000);
    chk("idle_ignore", {31'b0, bus.editing}, 32'd0);

    // Alarm edit from cleared shadow
    press(4'b0010);
    chk("alarm_target", {31'b0, bus.target_alarm}, 32'd1);
    chk("alarm_field", {30'b0, bus.field_sel}, 32'd1);
    chk("alarm_seed0", {8'b0, bus.hh_in, bus.mm_in, bus.ss_in}, 32'h00000000);
    inc_n(7);
    press(4'b0100);
    inc_n(30);
    exp_q.push_back({1'b1, 8'h07, 8'h30, 8'h00});
    press(4'b1000);
    chk("alarm_done", {31'b0, bus.editing}, 32'd0);

    press(4'b0010);
    chk("alarm_reseed", {8'b0, bus.hh_in, bus.mm_in, bus.ss_in}, 32'h00073000);
    chk("alarm_target2", {31'b0, bus.target_alarm}, 32'd1);

    // Idle timeout: still editing well before the limit, back to IDLE after it
    repeat (TMO - 40) @(negedge clk);
    chk("timeout_early", {31'b0, bus.editing}, 32'd1);
    repeat (40) @(negedge clk);
    chk("timeout_idle", {31'b0, bus.editing}, 32'd0);
    chk("timeout_keep", {8'b0, bus.hh_in, bus.mm_in, bus.ss_in}, 32'h00073000);

    // Simultaneous set+mode: set wins and commits the seeded time
    press(4'b0100);
    exp_q.push_back({1'b0, 8'h12, 8'h34, 8'h56});
    press(4'b1100);
    chk("prio_idle", {31'b0, bus.editing}, 32'd0);

    // Asynchronous reset mid-edit
    press(4'b0100);
    inc_n(1);
    chk("pre_reset", {24'b0, bus.hh_in}, 32'h13);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_editing", {29'b0, bus.editing, bus.field_sel}, 32'd0);
    chk("async_time", {8'b0, bus.hh_in, bus.mm_in, bus.ss_in}, 32'd0);
    chk("async_pulses", {30'b0, bus.load, bus.put_alarm}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_idle", {31'b0, bus.editing}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
